if_id_pipe_stage: RTL

Parametrised, handshaked pipeline register between instruction fetch (IF) and decode (ID). It carries the instruction word and its PC together under a valid/ready handshake. It supports a stall (hold) input and a flush (kill) input, and can optionally include a skid entry so that ready is registered without losing throughput. It is the successor to the fixed 32-bit IF/ID register: the PC is now registered alongside the instruction, and the block adds backpressure and bubble tracking that the old register lacked.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/if_id_pipe_stage_if.sv | 51 +++++
 rtl/pipe_skid_buf.sv | 117 +++++++++++
 rtl/if_id_pipe_stage.sv | 68 ++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline-register family (IF/ID, ID/EX, hazard
// unit).
//   pipe_state_t     occupancy state of a pipeline stage buffer
//   ST_EMPTY/ONE/TWO legal occupancy values
//   NOP_VAL_DEF      instruction word injected on bubbles and flushes
//                    (addi x0, x0, 0)
// -----------------------------------------------------------------------------
package pipe_pkg;

  typedef logic [1:0] pipe_state_t;

  localparam pipe_state_t ST_EMPTY = 2'd0;  // no entry held
  localparam pipe_state_t ST_ONE   = 2'd1;  // main register valid
  localparam pipe_state_t ST_TWO   = 2'd2;  // main and skid registers valid

  localparam logic [31:0] NOP_VAL_DEF = 32'h0000_0013;

endpackage : pipe_pkg

// File: rtl/if_id_pipe_stage_if.sv
// -----------------------------------------------------------------------------
// if_id_pipe_stage_if
// Signal bundle between instruction fetch, the IF/ID stage and decode.
//
// Handshake rules (both sides):
//   A beat transfers on a rising clk edge where valid and ready are both 1.
//   Once valid is raised, the producer holds valid and data stable until the
//   transfer happens. Ready may change freely. On the ID side, stall=1 blocks
//   the transfer exactly as out_ready=0 would. flush=1 kills every held beat
//   and the incoming beat. An upstream beat offered while flush=1 and
//   in_ready=1 still counts as consumed.
//
// Modports:
//   slave   the pipeline stage itself
//   master  the environment (IF + ID + hazard control)
// Signals:
//   in_valid/in_ready/in_insn/in_pc     fetch side
//   out_valid/out_ready/out_insn/out_pc decode side
//   flush, stall                        pipeline control
//   state_dbg                           current occupancy state (debug)
// -----------------------------------------------------------------------------
interface if_id_pipe_stage_if
  import pipe_pkg::*;
#(
  parameter int INSN_W = 32,
  parameter int PC_W   = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [INSN_W-1:0] in_insn;
  logic [PC_W-1:0]   in_pc;
  logic              flush;
  logic              stall;
  logic              out_valid;
  logic              out_ready;
  logic [INSN_W-1:0] out_insn;
  logic [PC_W-1:0]   out_pc;
  pipe_state_t       state_dbg;

  modport slave (
    input  in_valid, in_insn, in_pc, flush, stall, out_ready,
    output in_ready, out_valid, out_insn, out_pc, state_dbg
  );

  modport master (
    output in_valid, in_insn, in_pc, flush, stall, out_ready,
    input  in_ready, out_valid, out_insn, out_pc, state_dbg
  );

endinterface : if_id_pipe_stage_if

// File: rtl/pipe_skid_buf.sv
// -----------------------------------------------------------------------------
// pipe_skid_buf
// Generic valid/ready buffer of width W with an optional second (skid) entry.
//   SKID=1: two entries, in_ready comes straight from a flop, full throughput
//           under backpressure.
//   SKID=0: single entry, in_ready = ~out_valid | out_ready (combinational).
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   clear                    synchronous kill of all entries and of the
//                            incoming beat
//   in_valid/in_ready/in_data   upstream side
//   out_valid/out_ready/out_data downstream side
//   state                    occupancy state (ST_EMPTY/ST_ONE/ST_TWO)
// -----------------------------------------------------------------------------
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int W    = 64,
  parameter bit SKID = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output pipe_state_t  state
);

  pipe_state_t  state_q;
  pipe_state_t  state_d;
  logic [W-1:0] main_q;
  logic [W-1:0] skid_q;
  logic         ready_q;
  logic         acc;
  logic         take;
  logic         load_main_in;
  logic         load_main_skid;
  logic         load_skid_in;

  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;
  assign state     = state_q;
  assign take      = out_valid & out_ready;

  // With the skid entry, ready is a flop so IF never sees a path from ID.
  // Without it, ready must look at out_ready to keep one beat per cycle.
  assign in_ready = SKID ? ready_q : (~out_valid | out_ready);
  assign acc      = in_valid & in_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          state_d      = ST_ONE;
          load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (take && acc) begin
          load_main_in = 1'b1;
        end else if (take) begin
          state_d = ST_EMPTY;
        end else if (acc && SKID) begin
          // Main register is still being presented; park the beat.
          state_d      = ST_TWO;
          load_skid_in = 1'b1;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (take) begin
          state_d        = ST_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // A kill overrides everything: the beat on the outputs still leaves
    // (take above needs no action), but nothing new is captured.
    if (clear) begin
      state_d        = ST_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != ST_TWO);
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid_in) begin
        skid_q <= in_data;
      end
    end
  end

endmodule : pipe_skid_buf

// File: rtl/if_id_pipe_stage.sv
// -----------------------------------------------------------------------------
// if_id_pipe_stage
// Handshaked IF/ID pipeline register carrying instruction word and PC.
// Adds stall gating, flush and bubble masking around pipe_skid_buf.
//
// Build option:
//   IF_ID_SKID_EN defined   -> two-entry skid buffer, registered in_ready
//   IF_ID_SKID_EN undefined -> single entry, in_ready combinational from
//                              out_ready/stall
//
// Parameters: INSN_W, PC_W, NOP_VAL (word shown on out_insn when no beat).
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset
//   bus  if_id_pipe_stage_if.slave: in_valid/in_ready/in_insn/in_pc,
//        out_valid/out_ready/out_insn/out_pc, flush, stall, state_dbg
// -----------------------------------------------------------------------------
module if_id_pipe_stage
  import pipe_pkg::*;
#(
  parameter int                INSN_W  = 32,
  parameter int                PC_W    = 32,
  parameter logic [INSN_W-1:0] NOP_VAL = INSN_W'(NOP_VAL_DEF)
) (
  input  logic                clk,
  input  logic                rst,
  if_id_pipe_stage_if.slave   bus
);

`ifdef IF_ID_SKID_EN
  localparam bit SKID_EN = 1'b1;
`else
  localparam bit SKID_EN = 1'b0;
`endif

  localparam int DW = INSN_W + PC_W;

  logic          buf_out_valid;
  logic          buf_out_ready;
  logic [DW-1:0] buf_in_data;
  logic [DW-1:0] buf_out_data;

  // stall freezes the main register exactly like ID refusing the beat.
  assign buf_out_ready = bus.out_ready & ~bus.stall;
  assign buf_in_data   = {bus.in_insn, bus.in_pc};

  pipe_skid_buf #(
    .W    (DW),
    .SKID (SKID_EN)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (bus.flush),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (buf_in_data),
    .out_valid (buf_out_valid),
    .out_ready (buf_out_ready),
    .out_data  (buf_out_data),
    .state     (bus.state_dbg)
  );

  // Bubbles look like a NOP with PC 0 so ID never decodes stale contents.
  assign bus.out_valid = buf_out_valid;
  assign bus.out_insn  = buf_out_valid ? buf_out_data[DW-1:PC_W] : NOP_VAL;
  assign bus.out_pc    = buf_out_valid ? buf_out_data[PC_W-1:0] : '0;

endmodule : if_id_pipe_stage
